// File: rtl/serrecv.sv
// Serial frame receiver: hunts for sfs, verifies frame spacing, then deserializes each
// locked frame into WORD_W-bit words with a one-cycle valid strobe and framing-error counting.
module serrecv #(
  parameter int unsigned FRAME_BITS  = 256,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                                  sclk,
  input  logic                                  rstn,
  input  logic                                  enable,
  input  logic                                  sdata,
  input  logic                                  sfs,
  input  logic                                  err_clr,
  output logic [WORD_W-1:0]                     word_out,
  output logic                                  word_valid,
  output logic [$clog2(FRAME_BITS/WORD_W)-1:0]  word_idx,
  output logic                                  locked,
  output logic                                  frame_err,
  output logic [7:0]                            err_count
);

  localparam int unsigned CntW = $clog2(FRAME_BITS);
  localparam int unsigned SubW = $clog2(WORD_W);
  localparam int unsigned IdxW = $clog2(FRAME_BITS / WORD_W);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]        good_cnt_q, good_cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        errc_q, errc_d;

  logic              at_exp;
  logic              word_end;
  logic [CntW-1:0]   bit_inc;
  logic [3:0]        good_inc;
  logic [WORD_W-1:0] shifted;

  // bit_cnt holds the frame position of the bit about to be sampled; zero means sfs is due.
  assign at_exp   = (bit_cnt_q == '0);
  assign word_end = (bit_cnt_q[SubW-1:0] == SubW'(WORD_W - 1));
  assign bit_inc  = bit_cnt_q + 1'b1;
  assign good_inc = good_cnt_q + 4'd1;
  assign shifted  = {shreg_q[WORD_W-2:0], sdata};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    good_cnt_d = good_cnt_q;
    shreg_d    = shreg_q;
    word_d     = word_q;
    idx_d      = idx_q;
    errc_d     = errc_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (enable) begin
      unique case (state_q)
        StHunt: begin
          if (sfs) begin
            bit_cnt_d  = CntW'(1);
            good_cnt_d = '0;
            state_d    = StVerify;
          end
        end

        StVerify: begin
          bit_cnt_d = bit_inc;
          if (at_exp && sfs) begin
            good_cnt_d = good_inc;
            if (good_inc == 4'(LOCK_FRAMES)) begin
              // The locking sfs bit is bit 0 of the first delivered frame.
              state_d = StLocked;
              shreg_d = shifted;
            end
          end else if (sfs) begin
            ferr_d     = 1'b1;
            bit_cnt_d  = CntW'(1);
            good_cnt_d = '0;
          end else if (at_exp) begin
            ferr_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = StHunt;
          end
        end

        StLocked: begin
          if (at_exp && !sfs) begin
            ferr_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = StHunt;
          end else if (!at_exp && sfs) begin
            ferr_d     = 1'b1;
            bit_cnt_d  = CntW'(1);
            good_cnt_d = '0;
            state_d    = StVerify;
          end else begin
            bit_cnt_d = bit_inc;
            shreg_d   = shifted;
            if (word_end) begin
              word_d  = shifted;
              valid_d = 1'b1;
              idx_d   = bit_cnt_q[CntW-1:SubW];
            end
          end
        end

        default: begin
          state_d   = StHunt;
          bit_cnt_d = '0;
        end
      endcase

      if (err_clr) begin
        errc_d = '0;
      end else if (ferr_d && (errc_q != 8'hFF)) begin
        errc_d = errc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StHunt;
      bit_cnt_q  <= '0;
      good_cnt_q <= '0;
      shreg_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      idx_q      <= '0;
      errc_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      good_cnt_q <= good_cnt_d;
      shreg_q    <= shreg_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      idx_q      <= idx_d;
      errc_q     <= errc_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign word_idx   = idx_q;
  assign locked     = (state_q == StLocked);
  assign frame_err  = ferr_q;
  assign err_count  = errc_q;

endmodule

// File: doc/serrecv.md
# serrecv

Serial frame receiver and deserializer for the sclk serial link: the receive end of the sdata/sfs stream produced by the testbench serial generator. Hunts for the serial frame sync, verifies frame spacing, then delivers each 256-bit frame as eight 32-bit parallel words with a one-cycle valid strobe. It also detects and counts framing errors. It sits between the serial link and the parallel audio datapath, and is synthesizable.

## Interface
- FRAME_BITS, 256: bits per frame. Must be a power of 2 and a multiple of WORD_W.
- WORD_W, 32: bits per output word.
- LOCK_FRAMES, 2: consecutive correctly spaced sfs required after the first sfs before declaring lock (1..15).
- sclk  input  1  serial bit clock.
- rstn  input  1  reset; asynchronous, active-low.
- enable  input  1  bit strobe. sdata/sfs are sampled only on sclk edges with enable=1.
- sdata  input  1  serial data, MSB of each word first.
- sfs  input  1  frame sync; high coincident with bit 0 of a frame.
- err_clr  input  1  synchronous clear of err_count.
- word_out  output  WORD_W  last completed word, held until the next word.
- word_valid  output  1  one-cycle pulse: word_out updated.
- word_idx  output  log2(FRAME_BITS/WORD_W)  word index within its frame (0..7).
- locked  output  1  high in LOCKED state.
- frame_err  output  1  one-cycle pulse per detected framing error.
- err_count  output  8  framing error count, saturates at 255.

## Operation
- Internal state: bit_cnt (log2 FRAME_BITS, wraps to 0), shift register (WORD_W), good_cnt (4b).
- All state advances only on sampled cycles (enable=1); with enable=0 all state holds and pulses deassert.
- bit_cnt is "expected position": on each sampled bit, bit_cnt==0 means an sfs is expected.
- HUNT: ignore sdata until sfs=1. On sfs, set bit_cnt=1, good_cnt=0, go VERIFY.
- VERIFY:
  - Expected position with sfs=1: good_cnt++. If good_cnt reaches LOCK_FRAMES, go LOCKED; this bit is bit 0 of the first delivered frame.
  - sfs=1 at a non-expected position: frame_err. Restart VERIFY with this bit as bit 0 (bit_cnt=1, good_cnt=0).
  - Expected position with sfs=0: frame_err, go HUNT.
- LOCKED:
  - Shift sdata into the shift register, MSB first.
  - When the sampled bit has bit_cnt[log2 WORD_W-1:0]==WORD_W-1, load word_out with the full word, pulse word_valid, set word_idx = bit_cnt / WORD_W.
  - Misplaced sfs: frame_err, locked drops, go VERIFY with this bit as bit 0.
  - Missing sfs at the expected position: frame_err, go HUNT.
  - On any error the partially assembled word is discarded and never output.
- Words are emitted only from LOCKED, so every delivered word lies wholly within a verified frame.
- err_count: +1 per frame_err and saturates at 255. err_clr forces 0 and has priority over a simultaneous error. It is cleared only by err_clr or reset.

## Timing
- Reset values: word_out=0, word_valid=0, word_idx=0, locked=0, frame_err=0, err_count=0, state=HUNT, bit_cnt=0, good_cnt=0.
- Reset is asynchronous and may occur mid-frame. All state returns to HUNT immediately, and relock requires LOCK_FRAMES+1 sfs again.
- word_valid latency: asserted on the sclk edge that samples the word's last bit, so it is visible the cycle after that bit is on sdata. It is high for exactly one sclk cycle even if enable stays high.
- frame_err is registered on the edge that samples the offending bit (a one-cycle pulse). locked falls on that same edge.
- locked rises on the edge sampling the LOCK_FRAMES-th verified sfs after the first one. With defaults, that is the third sfs overall, and the first word_valid (word_idx=0) follows 32 sampled bits later.
- Back-to-back: with continuous enable, one word_valid every WORD_W cycles, and word_idx sequences 0..7 and wraps.

## Test plan
- Reset, then the generator with enable=1, directData=1, ddata=1 -> locked rises at the third sfs; word_valid every 32 cycles with word_out=0xFFFFFFFF and word_idx 0,1,…,7,0; frame_err never asserted.
- ddata alternating 1,0 starting at frame bit 0 -> every word_out=0xAAAAAAAA (MSB first).
- While locked, inject sfs at frame bit 100 -> frame_err pulse, err_count=1, locked=0; no word 3 output; relock 2 frames later with word_idx restarting at 0 aligned to the new sfs.
- While locked, suppress one sfs -> frame_err, state HUNT, locked=0; relock after 3 further sfs.
- Random enable gaps (~50% duty) with random data -> words match the generator's bits exactly, and the word_valid count equals 8 per locked frame.
- Repeated misplaced sfs, 300 errors -> err_count saturates at 255; err_clr asserted together with an error -> err_count=0. Assert rstn mid-word -> all outputs return to their reset values immediately.
